// File: rtl/vga_pkg.sv
// Shared definitions for the VGA plotter slice.
//   MODE_*   : frame mode encoding (copy from memory / solid fill)
//   COL_*    : common 3-bit colours
//   X_W, Y_W : pixel coordinate widths on the VGA write port
//   state_t  : plotter FSM encoding
package vga_pkg;
  localparam logic       MODE_COPY = 1'b0;
  localparam logic       MODE_FILL = 1'b1;
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam int         X_W       = 8;
  localparam int         Y_W       = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/vga_plotter_if.sv
// Bus bundle between the plotter and its environment.
//   control : start, mode, fg_colour, bg_colour in; busy, done out
//   memory  : mem_addr, mem_rd out; mem_data in (one cycle after the read)
//   pixel   : x, y, colour, plot out
// master = plotter side, slave = CPU / memory / VGA wrapper side.
interface vga_plotter_if #(
  parameter int ADDR_W = 14
) ();
  logic                     start;
  logic                     mode;
  logic [2:0]               fg_colour;
  logic [2:0]               bg_colour;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_rd;
  logic                     mem_data;
  logic [vga_pkg::X_W-1:0]  x;
  logic [vga_pkg::Y_W-1:0]  y;
  logic [2:0]               colour;
  logic                     plot;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, mode, fg_colour, bg_colour, mem_data,
    output mem_addr, mem_rd, x, y, colour, plot, busy, done
  );

  modport slave (
    output start, mode, fg_colour, bg_colour, mem_data,
    input  mem_addr, mem_rd, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/vga_scan_counter.sv
// Row-major raster counters for the plotter.
//   clock, reset : clock / async active-low reset
//   clear        : load col=row=addr=0 (wins over enable)
//   enable       : advance one pixel
//   col, row     : current pixel coordinate
//   addr         : linear address, kept equal to row*WIDTH+col by
//                  stepping alongside the coordinates (no multiplier)
//   last         : current pixel is (WIDTH-1, HEIGHT-1)
module vga_scan_counter
  import vga_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [X_W-1:0]    col,
  output logic [Y_W-1:0]    row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam logic [X_W-1:0] COL_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] ROW_LAST = Y_W'(HEIGHT - 1);

  logic col_wrap;
  assign col_wrap = (col == COL_LAST);
  assign last     = col_wrap && (row == ROW_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (enable) begin
      addr <= addr + ADDR_W'(1);
      if (col_wrap) begin
        col <= '0;
        row <= row + Y_W'(1);
      end else begin
        col <= col + X_W'(1);
      end
    end
  end
endmodule

// File: rtl/vga_plotter.sv
// Frame-copy engine feeding the VGA pixel-write port.
//   clock, reset : clock / async active-low reset
//   bus          : vga_plotter_if master (control, memory read, pixel write)
// A start pulse in IDLE latches mode/colours and scans WIDTH*HEIGHT pixels.
// The address goes out combinationally in RUN; memory answers one cycle
// later, which lines up with the registered coordinates and plot strobe,
// so the colour mux is taken straight from mem_data.
module vga_plotter
  import vga_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 14
) (
  input  logic          clock,
  input  logic          reset,
  vga_plotter_if.master bus
);
  state_t state, state_nxt;

  logic              clr, en, last;
  logic [X_W-1:0]    col;
  logic [Y_W-1:0]    row;
  logic [ADDR_W-1:0] addr;

  logic              mode_q;
  logic [2:0]        fg_q, bg_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic              plot_q;

  vga_scan_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_scan (
    .clock (clock),
    .reset (reset),
    .clear (clr),
    .enable(en),
    .col   (col),
    .row   (row),
    .addr  (addr),
    .last  (last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    en        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          clr       = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        en = 1'b1;
        if (last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Frame parameters are frozen at start so mid-frame input changes are inert.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_COPY;
      fg_q   <= COL_BLACK;
      bg_q   <= COL_BLACK;
    end else if (state == ST_IDLE && bus.start) begin
      mode_q <= bus.mode;
      fg_q   <= bus.fg_colour;
      bg_q   <= bus.bg_colour;
    end
  end

  // Output stage: one register behind the issued address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      plot_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      plot_q <= (state == ST_RUN);
      if (state == ST_RUN) begin
        x_q <= col;
        y_q <= row;
      end
    end
  end

  assign bus.mem_addr = addr;
  assign bus.mem_rd   = (state == ST_RUN) && (mode_q == MODE_COPY);
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.plot     = plot_q;
  assign bus.colour   = (mode_q == MODE_FILL) ? bg_q
                      : (bus.mem_data ? fg_q : bg_q);
  assign bus.busy     = (state == ST_RUN) || (state == ST_DRAIN);
  assign bus.done     = (state == ST_DONE);
endmodule

// File: tb/tb_vga_plotter.sv
// Self-checking bench: three plotter instances (4x3, 1x1, 128x120) share a
// clock, reset and a bit-addressed memory; one is active at a time via sel.
// Expected per-cycle behaviour comes from frame arithmetic: pixel i plots
// at cycle i+2 at (i%W, i/W), done at N+2, busy over 1..N+1.
module tb_vga_plotter;
  logic clock;
  logic reset;
  logic start;
  logic mode;
  logic [2:0] fg, bg;
  int sel;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit mem [0:16383];

  vga_plotter_if #(.ADDR_W(4))  if_a ();
  vga_plotter_if #(.ADDR_W(1))  if_b ();
  vga_plotter_if #(.ADDR_W(14)) if_c ();

  vga_plotter #(.WIDTH(4),   .HEIGHT(3),   .ADDR_W(4))  u_a (.clock(clock), .reset(reset), .bus(if_a));
  vga_plotter #(.WIDTH(1),   .HEIGHT(1),   .ADDR_W(1))  u_b (.clock(clock), .reset(reset), .bus(if_b));
  vga_plotter #(.WIDTH(128), .HEIGHT(120), .ADDR_W(14)) u_c (.clock(clock), .reset(reset), .bus(if_c));

  assign if_a.start = start && (sel == 0);
  assign if_b.start = start && (sel == 1);
  assign if_c.start = start && (sel == 2);
  assign if_a.mode = mode;  assign if_a.fg_colour = fg;  assign if_a.bg_colour = bg;
  assign if_b.mode = mode;  assign if_b.fg_colour = fg;  assign if_b.bg_colour = bg;
  assign if_c.mode = mode;  assign if_c.fg_colour = fg;  assign if_c.bg_colour = bg;

  // Synchronous 1-bit memory: data one cycle after the read strobe.
  always @(posedge clock) begin
    if (if_a.mem_rd) if_a.mem_data <= mem[if_a.mem_addr];
    if (if_b.mem_rd) if_b.mem_data <= mem[if_b.mem_addr];
    if (if_c.mem_rd) if_c.mem_data <= mem[if_c.mem_addr];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic        o_plot, o_busy, o_done, o_rd;
  logic [7:0]  o_x;
  logic [6:0]  o_y;
  logic [2:0]  o_col;
  logic [13:0] o_addr;

  always_comb begin
    o_plot = 1'b0; o_busy = 1'b0; o_done = 1'b0; o_rd = 1'b0;
    o_x = '0; o_y = '0; o_col = '0; o_addr = '0;
    case (sel)
      0: begin
        o_plot = if_a.plot; o_busy = if_a.busy; o_done = if_a.done; o_rd = if_a.mem_rd;
        o_x = if_a.x; o_y = if_a.y; o_col = if_a.colour; o_addr = 14'(if_a.mem_addr);
      end
      1: begin
        o_plot = if_b.plot; o_busy = if_b.busy; o_done = if_b.done; o_rd = if_b.mem_rd;
        o_x = if_b.x; o_y = if_b.y; o_col = if_b.colour; o_addr = 14'(if_b.mem_addr);
      end
      default: begin
        o_plot = if_c.plot; o_busy = if_c.busy; o_done = if_c.done; o_rd = if_c.mem_rd;
        o_x = if_c.x; o_y = if_c.y; o_col = if_c.colour; o_addr = 14'(if_c.mem_addr);
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s sel=%0d cyc=%0d got=%0h exp=%0h", tag, sel, cyc, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_plot"}, 32'(o_plot), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_rd"},   32'(o_rd),   0);
    chk({tag, "_addr"}, 32'(o_addr), 0);
    chk({tag, "_x"},    32'(o_x),    0);
    chk({tag, "_y"},    32'(o_y),    0);
    chk({tag, "_col"},  32'(o_col),  0);
  endtask

  // One frame on the selected instance. repulse: cycle to re-assert start
  // (0 = none). rst_at: cycle to pull reset low and abort (0 = none).
  task automatic run_frame(input int w, input int h, input logic m,
                           input logic [2:0] f, input logic [2:0] b,
                           input int repulse, input int rst_at);
    int n, plots, dones, last_addr, i;
    logic [2:0] ecol;
    n = w * h; plots = 0; dones = 0; last_addr = -1;
    @(negedge clock);
    start = 1'b1; mode = m; fg = f; bg = b;
    @(posedge clock);
    for (int c = 1; c <= n + 3; c++) begin
      @(negedge clock);
      cyc = c;
      if (c == 1) begin
        start = 1'b0;
        mode = 1'($urandom); fg = 3'($urandom); bg = 3'($urandom);
      end
      if (repulse != 0 && c == repulse)     start = 1'b1;
      if (repulse != 0 && c == repulse + 1) start = 1'b0;
      if (c == rst_at) begin
        reset = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        return;
      end
      chk("busy", 32'(o_busy), 32'(c >= 1 && c <= n + 1));
      chk("done", 32'(o_done), 32'(c == n + 2));
      chk("plot", 32'(o_plot), 32'(c >= 2 && c <= n + 1));
      chk("mem_rd", 32'(o_rd), 32'(m == 1'b0 && c <= n));
      if (o_rd) last_addr = int'(o_addr);
      if (m == 1'b0 && c <= n) chk("mem_addr", 32'(o_addr), 32'(c - 1));
      if (o_plot) plots++;
      if (o_done) dones++;
      if (c >= 2 && c <= n + 1) begin
        i = c - 2;
        ecol = m ? b : (mem[i] ? f : b);
        chk("x", 32'(o_x), 32'(i % w));
        chk("y", 32'(o_y), 32'(i / w));
        chk("colour", 32'(o_col), 32'(ecol));
      end
    end
    chk("plot_count", 32'(plots), 32'(n));
    chk("done_count", 32'(dones), 32'd1);
    if (m == 1'b0) chk("last_addr", 32'(last_addr), 32'(n - 1));
  endtask

  initial begin
    logic [11:0] pat;
    reset = 1'b0; start = 1'b0; mode = 1'b0; fg = '0; bg = '0; sel = 0;
    repeat (3) @(negedge clock);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_idle_outputs("reset_state");
    end
    sel = 0;
    @(negedge clock);
    reset = 1'b1;

    // 4x3 copy of 0xA5A, white on black
    pat = 12'hA5A;
    for (int k = 0; k < 12; k++) mem[k] = pat[k];
    run_frame(4, 3, 1'b0, 3'b111, 3'b000, 0, 0);
    // Fill mode
    run_frame(4, 3, 1'b1, 3'($urandom), 3'b100, 0, 0);
    // start re-pulsed mid-frame
    run_frame(4, 3, 1'b0, 3'b010, 3'b101, 5, 0);
    // Reset at cycle 6, then a clean frame
    run_frame(4, 3, 1'b0, 3'b111, 3'b001, 0, 6);
    run_frame(4, 3, 1'b0, 3'b011, 3'b110, 0, 0);
    // Random 4x3 frames
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 12; k++) mem[k] = 1'($urandom);
      run_frame(4, 3, 1'($urandom), 3'($urandom), 3'($urandom), 0, 0);
    end

    // 1x1
    sel = 1;
    for (int r = 0; r < 3; r++) begin
      mem[0] = 1'($urandom);
      run_frame(1, 1, 1'b0, 3'($urandom), 3'($urandom), 0, 0);
    end
    run_frame(1, 1, 1'b1, 3'($urandom), 3'($urandom), 0, 0);

    // Full size, random memory
    sel = 2;
    for (int k = 0; k < 15360; k++) mem[k] = 1'($urandom);
    run_frame(128, 120, 1'b0, 3'($urandom), 3'($urandom), 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_plotter.md
Name: vga_plotter

Overview:
- Frame-copy engine that produces the pixel-write stream consumed by the VGA pixel-write interface (x, y, colour, plot).
- Scans a 1-bit-per-pixel video memory in row-major order, maps each bit to a foreground or background colour, and issues one plot strobe per pixel.
- Also supports a fill mode that paints the whole drawing area one colour without reading memory.
- Sits between the CPU-side video memory and the VGA wrapper; the CPU starts a refresh with a single pulse and watches busy/done.

Parameters:
- WIDTH, 128, pixels per row; 1..256.
- HEIGHT, 120, rows; 1..128.
- ADDR_W, 14, video memory address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a frame; sampled only in IDLE.
- mode  in  1  0 = copy from memory, 1 = fill; latched at start.
- fg_colour  in  3  colour for memory bit 1; latched at start.
- bg_colour  in  3  colour for memory bit 0, and the fill colour in mode 1; latched at start.
- mem_addr  out  ADDR_W  video memory read address.
- mem_rd  out  1  read enable; memory returns mem_data exactly one cycle later.
- mem_data  in  1  pixel bit addressed in the previous cycle.
- x  out  8  pixel column, zero-extended.
- y  out  7  pixel row, zero-extended.
- colour  out  3  pixel colour.
- plot  out  1  write strobe; x, y and colour are valid only when plot=1.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - mem_addr, mem_rd, x, y, colour, plot, busy and done all go to 0.
  - Latched mode and colours clear to 0.
  - Reset during a frame aborts it immediately; no done pulse is produced and there is no resume.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches mode and both colours.
  - Clears the scan counters to col=0, row=0, addr=0.
  - Next state is RUN; busy=1 from that next cycle.
- RUN: every cycle
  - Drives mem_addr=addr and mem_rd = (mode==0).
  - Stage-1 register captures col/row.
  - Counters advance: col+1; at col==WIDTH-1, col wraps to 0 and row increments.
  - addr increments by 1 every cycle with no multiply; it must equal row*WIDTH+col at all times.
  - When the issued pixel is (WIDTH-1, HEIGHT-1), next state is DRAIN.
- Output stage: one register stage behind the address.
  - plot is the stage-1 valid bit delayed one cycle.
  - x and y are the registered stage-1 coordinates.
  - colour = mode ? bg_colour : (mem_data ? fg_colour : bg_colour).
  - First plot (x=0, y=0) occurs 2 cycles after the cycle in which start was sampled.
  - plot stays high for exactly WIDTH*HEIGHT consecutive cycles, with no gaps.
- DRAIN:
  - mem_rd=0 and the last pixel is plotted.
  - Next state is DONE.
- DONE:
  - done=1, busy=0, plot=0 for one cycle.
  - Next state is IDLE.
- start arriving in RUN, DRAIN or DONE is ignored, not queued.
- Colour or mode inputs changing mid-frame have no effect.
- x and y outputs hold their last value when plot=0; consumers ignore them.
- Degenerate sizes:
  - WIDTH=1: row increments every cycle.
  - WIDTH=1, HEIGHT=1: RUN lasts one cycle, then DRAIN.
- Total frame time, from the start-sample cycle to the done cycle: WIDTH*HEIGHT+2 cycles.

Decomposition:
- Shared package vga_pkg:
  - MODE_COPY=1'b0, MODE_FILL=1'b1.
  - 3-bit colour constants COL_BLACK=3'b000 and COL_WHITE=3'b111.
  - Plotter state encoding (IDLE, RUN, DRAIN, DONE).
  - Coordinate widths X_W=8 and Y_W=7.
- One sub-module, vga_scan_counter:
  - Contains the col/row/addr counters, clear and enable inputs, and the combinational last-pixel flag.
  - Parameterised by WIDTH, HEIGHT and ADDR_W.
- The FSM, output stage and colour mux stay in vga_plotter.

Test Plan:
- WIDTH=4, HEIGHT=3, copy mode, memory bits = 0xA5A (addr 0 = LSB), fg=3'b111, bg=3'b000.
  - Required: 12 consecutive plots starting 2 cycles after start.
  - Order is (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2), and colour at each pixel follows the memory bit.
  - done pulses at cycle 14 after start; busy covers cycles 1–13.
- Fill mode, bg=3'b100, same size.
  - Required: 12 plots, all colour=3'b100, mem_rd never asserted.
- start re-pulsed at cycle 5 of a frame.
  - Required: ignored; exactly one done, 12 plots total.
- reset driven low at cycle 6 of a frame.
  - Required: plot, busy, done and mem_rd drop to 0 asynchronously.
  - A new start after release produces a full 12-plot frame from (0,0).
- WIDTH=1, HEIGHT=1.
  - Required: one plot at (0,0) at cycle 2, done at cycle 3.
- Default size (128×120), copy mode, random memory.
  - Required: 15360 plots, last at (127,119) with mem_addr 15359.
  - A scoreboard matches every colour to its memory bit.
